reg_write_arbiter: RTL



---
 rtl/arb_defs_pkg.sv | 16 +
 rtl/reg_write_arbiter_rr_pick.sv | 36 +++
 rtl/reg_write_arbiter.sv | 85 ++++++++
 3 files changed

// File: rtl/arb_defs_pkg.sv
// Shared constants and helpers for the register-bank write arbiter.
// Optional stall-cycle counter is enabled by defining ARB_STALL_CNT_EN.
package arb_defs_pkg;

    localparam int unsigned ARB_NREQ      = 4;
    localparam int unsigned ARB_AW        = 3;
    localparam int unsigned ARB_DW        = 8;
    localparam int unsigned STALL_CNT_W   = 16;
    localparam logic [STALL_CNT_W-1:0] STALL_CNT_MAX = 16'hFFFF;

    // Lowest bit position of element idx in a flattened bus of width-w elements.
    function automatic int unsigned slice_lo(input int unsigned idx, input int unsigned w);
        return idx * w;
    endfunction

endpackage

// File: rtl/reg_write_arbiter_rr_pick.sv
// Combinational rotating-priority search: first set Req bit at or after Ptr wins.
// Stall suppresses every grant.
module rr_pick
    import arb_defs_pkg::*;
#(
    parameter int unsigned NREQ = ARB_NREQ,
    parameter int unsigned IW   = 2
) (
    input  logic [NREQ-1:0] Req,
    input  logic [IW-1:0]   Ptr,
    input  logic            Stall,
    output logic [NREQ-1:0] Gnt,
    output logic [IW-1:0]   Idx,
    output logic            Found
);

    int unsigned pos;

    always_comb begin
        Gnt   = '0;
        Idx   = '0;
        Found = 1'b0;
        pos   = 0;
        if (!Stall) begin
            for (int unsigned k = 0; k < NREQ; k++) begin
                pos = (32'(Ptr) + k) % NREQ;
                if (!Found && Req[pos]) begin
                    Found    = 1'b1;
                    Idx      = IW'(pos);
                    Gnt[pos] = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for the single register-bank write port, with registered output.
// Define ARB_STALL_CNT_EN to build the saturating stall-cycle counter.
module reg_write_arbiter
    import arb_defs_pkg::*;
#(
    parameter int unsigned NREQ = ARB_NREQ,
    parameter int unsigned AW   = ARB_AW,
    parameter int unsigned DW   = ARB_DW,
    parameter int unsigned IW   = 2
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    input  logic [NREQ-1:0]        Req,
    input  logic [NREQ*AW-1:0]     WrAddrIn,
    input  logic [NREQ*DW-1:0]     WrDataIn,
    input  logic                   Stall,
    output logic [NREQ-1:0]        Gnt,
    output logic                   WrEn,
    output logic [AW-1:0]          WrAddr,
    output logic [DW-1:0]          WrData,
    output logic [IW-1:0]          WrSrc,
    output logic [STALL_CNT_W-1:0] StallCnt
);

    logic [IW-1:0]   ptr;
    logic [IW-1:0]   win;
    logic            found;
    logic [NREQ-1:0] pick_gnt;
    logic [IW-1:0]   ptr_nxt;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .Req   (Req),
        .Ptr   (ptr),
        .Stall (Stall),
        .Gnt   (pick_gnt),
        .Idx   (win),
        .Found (found)
    );

    // Reset must also silence the combinational grant, not just the registers.
    assign Gnt = Rst_n ? pick_gnt : '0;

    always_comb begin
        ptr_nxt = '0;
        if (win != IW'(NREQ - 1))
            ptr_nxt = win + 1'b1;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            ptr    <= '0;
            WrEn   <= 1'b0;
            WrAddr <= '0;
            WrData <= '0;
            WrSrc  <= '0;
        end else begin
            WrEn <= found;
            if (found) begin
                ptr    <= ptr_nxt;
                WrAddr <= WrAddrIn[slice_lo(32'(win), AW) +: AW];
                WrData <= WrDataIn[slice_lo(32'(win), DW) +: DW];
                WrSrc  <= win;
            end
        end
    end

`ifdef ARB_STALL_CNT_EN
    logic [STALL_CNT_W-1:0] stall_cnt;

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n)
            stall_cnt <= '0;
        else if (Stall && (|Req) && (stall_cnt != STALL_CNT_MAX))
            stall_cnt <= stall_cnt + 1'b1;
    end

    assign StallCnt = stall_cnt;
`else
    assign StallCnt = '0;
`endif

endmodule
